// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780 frame sequencer.
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_POWER_WAIT,
    ST_INIT,
    ST_IDLE,
    ST_ADDR1,
    ST_ROW1,
    ST_ADDR2,
    ST_ROW2,
    ST_DONE
  } seq_state_t;

  typedef enum logic [1:0] {
    BW_IDLE,
    BW_SETUP,
    BW_PULSE,
    BW_WAIT
  } bw_state_t;

  localparam logic [7:0] CMD_FUNC_SET = 8'h38;
  localparam logic [7:0] CMD_DISP_ON  = 8'h0C;
  localparam logic [7:0] CMD_CLEAR    = 8'h01;
  localparam logic [7:0] CMD_ENTRY    = 8'h06;
  localparam logic [7:0] CMD_ROW1     = 8'h80;
  localparam logic [7:0] CMD_ROW2     = 8'hC0;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic [7:0] init_cmd(input logic [1:0] i);
    logic [7:0] c;
    case (i)
      2'd0:    c = CMD_FUNC_SET;
      2'd1:    c = CMD_DISP_ON;
      2'd2:    c = CMD_CLEAR;
      default: c = CMD_ENTRY;
    endcase
    return c;
  endfunction

  // Character k of a row; k = 0 is the leftmost (most significant) byte.
  function automatic logic [7:0] char_at(input logic [127:0] line, input logic [3:0] k);
    return line[127 - 8 * int'(k) -: 8];
  endfunction

endpackage

// File: rtl/lcd_byte_writer.sv
// Single-byte LCD write: SETUP (E low) -> PULSE (E high) -> WAIT (E low).
// Ports: start/rs/data/long_wait request a byte; done is high in the last
// WAIT cycle, when a new start is accepted with no idle gap.
module lcd_byte_writer
  import lcd_pkg::*;
#(
  parameter int unsigned SETUP_CYCLES      = 10,
  parameter int unsigned E_PULSE_CYCLES    = 50,
  parameter int unsigned CMD_WAIT_CYCLES   = 5_000,
  parameter int unsigned CLEAR_WAIT_CYCLES = 200_000,
  parameter int unsigned TIMER_W           = 19
) (
  input  logic       Clock_100MHz,
  input  logic       Clear,
  input  logic       start,
  input  logic       rs,
  input  logic [7:0] data,
  input  logic       long_wait,
  output logic       done,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic [7:0] lcd_data
);

  bw_state_t          state;
  logic [TIMER_W-1:0] timer;
  logic               long_q;

  assign done = (state == BW_WAIT) && (timer == '0);

  always_ff @(posedge Clock_100MHz) begin
    if (Clear) begin
      state    <= BW_IDLE;
      timer    <= '0;
      long_q   <= 1'b0;
      lcd_e    <= 1'b0;
      lcd_rs   <= 1'b0;
      lcd_data <= '0;
    end else if (start && (state == BW_IDLE || done)) begin
      state    <= BW_SETUP;
      timer    <= TIMER_W'(SETUP_CYCLES - 1);
      long_q   <= long_wait;
      lcd_e    <= 1'b0;
      lcd_rs   <= rs;
      lcd_data <= data;
    end else begin
      case (state)
        BW_SETUP: begin
          if (timer == '0) begin
            state <= BW_PULSE;
            lcd_e <= 1'b1;
            timer <= TIMER_W'(E_PULSE_CYCLES - 1);
          end else begin
            timer <= timer - 1'b1;
          end
        end
        BW_PULSE: begin
          if (timer == '0) begin
            state <= BW_WAIT;
            lcd_e <= 1'b0;
            timer <= long_q ? TIMER_W'(CLEAR_WAIT_CYCLES - 1)
                            : TIMER_W'(CMD_WAIT_CYCLES - 1);
          end else begin
            timer <= timer - 1'b1;
          end
        end
        BW_WAIT: begin
          if (timer == '0) state <= BW_IDLE;
          else             timer <= timer - 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/lcd_frame_sequencer.sv
// HD44780 16x2 driver: power-up wait, init commands, then 34-byte frames
// (row address + 16 chars per row) from a snapshot of Line_1/Line_2.
// Ports: Refresh requests a frame; Busy/Frame_done report status;
// LCD_RS/LCD_RW/LCD_E/LCD_Data drive the panel.
// Optional: LCD_AUTO_REFRESH_EN adds a periodic internal frame request.
module lcd_frame_sequencer
  import lcd_pkg::*;
#(
  parameter int unsigned POWER_WAIT_CYCLES = 2_000_000,
  parameter int unsigned SETUP_CYCLES      = 10,
  parameter int unsigned E_PULSE_CYCLES    = 50,
  parameter int unsigned CMD_WAIT_CYCLES   = 5_000,
  parameter int unsigned CLEAR_WAIT_CYCLES = 200_000,
  parameter int unsigned REFRESH_CYCLES    = 10_000_000
) (
  input  logic         Clock_100MHz,
  input  logic         Clear,
  input  logic [127:0] Line_1,
  input  logic [127:0] Line_2,
  input  logic         Refresh,
  output logic         Busy,
  output logic         Frame_done,
  output logic         LCD_RS,
  output logic         LCD_RW,
  output logic         LCD_E,
  output logic [7:0]   LCD_Data
);

  localparam int unsigned MAX_CYC =
    max_u(max_u(max_u(POWER_WAIT_CYCLES, SETUP_CYCLES), max_u(E_PULSE_CYCLES, CMD_WAIT_CYCLES)),
          max_u(CLEAR_WAIT_CYCLES, REFRESH_CYCLES));
  localparam int unsigned TIMER_W = $clog2(MAX_CYC) + 1;

  seq_state_t         state;
  logic [TIMER_W-1:0] power_cnt;
  logic [3:0]         idx;
  logic [255:0]       snap;
  logic               pending;
  logic               req;

  logic               wr_start;
  logic               wr_rs;
  logic [7:0]         wr_data;
  logic               wr_long;
  logic               wr_done;

  assign LCD_RW = 1'b0;

`ifdef LCD_AUTO_REFRESH_EN
  logic               auto_run;
  logic [TIMER_W-1:0] auto_cnt;
  logic               auto_req;

  // Counter loads zero at end of init so the first request lands in the first IDLE cycle.
  always_ff @(posedge Clock_100MHz) begin
    if (Clear) begin
      auto_run <= 1'b0;
      auto_cnt <= '0;
    end else if (state == ST_INIT && wr_done && idx == 4'd3) begin
      auto_run <= 1'b1;
      auto_cnt <= '0;
    end else if (auto_run) begin
      if (auto_cnt == '0) auto_cnt <= TIMER_W'(REFRESH_CYCLES - 1);
      else                auto_cnt <= auto_cnt - 1'b1;
    end
  end

  assign auto_req = auto_run && (auto_cnt == '0);
  assign req      = Refresh | auto_req;
`else
  assign req = Refresh;
`endif

  // Next byte is issued combinationally in the writer's done cycle so bytes run back to back.
  always_comb begin
    wr_start = 1'b0;
    wr_rs    = 1'b0;
    wr_data  = CMD_FUNC_SET;
    wr_long  = 1'b0;
    case (state)
      ST_POWER_WAIT: begin
        wr_start = (power_cnt == '0);
        wr_data  = CMD_FUNC_SET;
      end
      ST_INIT: begin
        wr_start = wr_done && (idx != 4'd3);
        wr_data  = init_cmd(idx[1:0] + 2'd1);
        wr_long  = (wr_data == CMD_CLEAR);
      end
      ST_IDLE: begin
        wr_start = req | pending;
        wr_data  = CMD_ROW1;
      end
      ST_ADDR1: begin
        wr_start = wr_done;
        wr_rs    = 1'b1;
        wr_data  = char_at(snap[255:128], 4'd0);
      end
      ST_ROW1: begin
        wr_start = wr_done;
        if (idx == 4'd15) begin
          wr_rs   = 1'b0;
          wr_data = CMD_ROW2;
        end else begin
          wr_rs   = 1'b1;
          wr_data = char_at(snap[255:128], idx + 4'd1);
        end
      end
      ST_ADDR2: begin
        wr_start = wr_done;
        wr_rs    = 1'b1;
        wr_data  = char_at(snap[127:0], 4'd0);
      end
      ST_ROW2: begin
        wr_start = wr_done && (idx != 4'd15);
        wr_rs    = 1'b1;
        wr_data  = char_at(snap[127:0], idx + 4'd1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clock_100MHz) begin
    if (Clear) begin
      state      <= ST_POWER_WAIT;
      power_cnt  <= TIMER_W'(POWER_WAIT_CYCLES - 1);
      idx        <= '0;
      snap       <= '0;
      pending    <= 1'b0;
      Busy       <= 1'b1;
      Frame_done <= 1'b0;
    end else begin
      Frame_done <= 1'b0;
      if (req && state != ST_IDLE) pending <= 1'b1;
      case (state)
        ST_POWER_WAIT: begin
          if (power_cnt == '0) begin
            state <= ST_INIT;
            idx   <= '0;
          end else begin
            power_cnt <= power_cnt - 1'b1;
          end
        end
        ST_INIT: begin
          if (wr_done) begin
            if (idx == 4'd3) begin
              state <= ST_IDLE;
              Busy  <= 1'b0;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        ST_IDLE: begin
          if (req || pending) begin
            state   <= ST_ADDR1;
            snap    <= {Line_1, Line_2};
            pending <= 1'b0;
            Busy    <= 1'b1;
          end
        end
        ST_ADDR1: begin
          if (wr_done) begin
            state <= ST_ROW1;
            idx   <= '0;
          end
        end
        ST_ROW1: begin
          if (wr_done) begin
            if (idx == 4'd15) state <= ST_ADDR2;
            else              idx   <= idx + 1'b1;
          end
        end
        ST_ADDR2: begin
          if (wr_done) begin
            state <= ST_ROW2;
            idx   <= '0;
          end
        end
        ST_ROW2: begin
          if (wr_done) begin
            if (idx == 4'd15) begin
              state      <= ST_DONE;
              Frame_done <= 1'b1;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          Busy  <= 1'b0;
        end
        default: state <= ST_POWER_WAIT;
      endcase
    end
  end

  lcd_byte_writer #(
    .SETUP_CYCLES      (SETUP_CYCLES),
    .E_PULSE_CYCLES    (E_PULSE_CYCLES),
    .CMD_WAIT_CYCLES   (CMD_WAIT_CYCLES),
    .CLEAR_WAIT_CYCLES (CLEAR_WAIT_CYCLES),
    .TIMER_W           (TIMER_W)
  ) u_writer (
    .Clock_100MHz (Clock_100MHz),
    .Clear        (Clear),
    .start        (wr_start),
    .rs           (wr_rs),
    .data         (wr_data),
    .long_wait    (wr_long),
    .done         (wr_done),
    .lcd_e        (LCD_E),
    .lcd_rs       (LCD_RS),
    .lcd_data     (LCD_Data)
  );

endmodule

// File: tb/tb_lcd_frame_sequencer.sv
module tb_lcd_frame_sequencer;

  localparam int PW  = 20;
  localparam int SU  = 2;
  localparam int EP  = 3;
  localparam int CW  = 5;
  localparam int CLW = 12;
  localparam int RF  = 400;

  localparam int P_PW    = 0;
  localparam int P_INIT  = 1;
  localparam int P_IDLE  = 2;
  localparam int P_FRAME = 3;
  localparam int P_DONE  = 4;

  typedef logic [8:0] wbyte_t;  // {rs, data}

  logic         Clock_100MHz = 1'b0;
  logic         Clear = 1'b1;
  logic         Refresh = 1'b0;
  logic [127:0] Line_1 = '0;
  logic [127:0] Line_2 = '0;
  logic         Busy, Frame_done, LCD_RS, LCD_RW, LCD_E;
  logic [7:0]   LCD_Data;

  always #5 Clock_100MHz = ~Clock_100MHz;

  lcd_frame_sequencer #(
    .POWER_WAIT_CYCLES (PW),
    .SETUP_CYCLES      (SU),
    .E_PULSE_CYCLES    (EP),
    .CMD_WAIT_CYCLES   (CW),
    .CLEAR_WAIT_CYCLES (CLW),
    .REFRESH_CYCLES    (RF)
  ) dut (
    .Clock_100MHz (Clock_100MHz),
    .Clear        (Clear),
    .Line_1       (Line_1),
    .Line_2       (Line_2),
    .Refresh      (Refresh),
    .Busy         (Busy),
    .Frame_done   (Frame_done),
    .LCD_RS       (LCD_RS),
    .LCD_RW       (LCD_RW),
    .LCD_E        (LCD_E),
    .LCD_Data     (LCD_Data)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model: byte list + elapsed time ----------------
  wbyte_t seq[$];
  int     t, pw_left, phase, ph0, mcyc = 0;
  bit     m_busy, m_pend, m_fd, m_req;
  wbyte_t m_last;
  bit     auto_on = 0;
  int     next_auto = 0;

  function automatic int period(wbyte_t b);
    return SU + EP + ((b == 9'h001) ? CLW : CW);
  endfunction

  function automatic int seq_total();
    int s = 0;
    foreach (seq[i]) s += period(seq[i]);
    return s;
  endfunction

  function automatic void exp_pins(output logic e, output wbyte_t b);
    int o, j;
    e = 1'b0;
    b = m_last;
    if ((phase == P_INIT || phase == P_FRAME) && seq.size() > 0) begin
      o = t;
      j = 0;
      while (j < seq.size() - 1 && o >= period(seq[j])) begin
        o -= period(seq[j]);
        j++;
      end
      b = seq[j];
      e = (o >= SU) && (o < SU + EP);
    end
  endfunction

  always @(posedge Clock_100MHz) begin
    mcyc++;
    m_req = Refresh;
`ifdef LCD_AUTO_REFRESH_EN
    if (auto_on && mcyc == next_auto) begin
      m_req = 1'b1;
      next_auto += RF;
    end
`endif
    ph0 = phase;
    if (Clear) begin
      phase = P_PW; pw_left = PW; seq.delete(); t = 0;
      m_busy = 1; m_pend = 0; m_fd = 0; m_last = '0; auto_on = 0;
    end else begin
      m_fd = 0;
      case (phase)
        P_PW: begin
          if (pw_left == 1) begin
            seq = '{9'h038, 9'h00C, 9'h001, 9'h006};
            t = 0;
            phase = P_INIT;
          end else pw_left--;
        end
        P_INIT, P_FRAME: begin
          t++;
          if (t == seq_total()) begin
            m_last = seq[seq.size() - 1];
            seq.delete();
            if (phase == P_INIT) begin
              phase = P_IDLE; m_busy = 0;
              auto_on = 1; next_auto = mcyc + 1;
            end else begin
              phase = P_DONE; m_fd = 1;
            end
          end
        end
        P_IDLE: begin
          if (m_req || m_pend) begin
            seq.delete();
            seq.push_back(9'h080);
            for (int k = 0; k < 16; k++) seq.push_back({1'b1, Line_1[127 - 8 * k -: 8]});
            seq.push_back(9'h0C0);
            for (int k = 0; k < 16; k++) seq.push_back({1'b1, Line_2[127 - 8 * k -: 8]});
            t = 0; phase = P_FRAME; m_busy = 1; m_pend = 0;
          end
        end
        default: begin  // P_DONE
          phase = P_IDLE; m_busy = 0;
        end
      endcase
      if (ph0 != P_IDLE && m_req) m_pend = 1;
    end
  end

  // ---------------- per-cycle compare + byte capture ----------------
  wbyte_t cap[$];
  int     fd_count = 0;
  logic   prev_e = 1'b0;

  function automatic wbyte_t cap_at(int i);
    return (i < cap.size()) ? cap[i] : 9'h1FF;
  endfunction

  always @(posedge Clock_100MHz) begin
    logic   ee;
    wbyte_t eb;
    #1;
    exp_pins(ee, eb);
    check("pins", {19'd0, LCD_E, LCD_RS, LCD_Data, LCD_RW, Busy, Frame_done},
                  {19'd0, ee, eb, 1'b0, m_busy, m_fd});
    if (prev_e && !LCD_E) cap.push_back({LCD_RS, LCD_Data});
    prev_e = LCD_E;
    if (Frame_done) fd_count++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // ---------------- stimulus ----------------
  initial begin
    int           n;
    logic [127:0] l1, l2;
    wbyte_t       exp_b;
    wbyte_t       init_exp[4];
    init_exp = '{9'h038, 9'h00C, 9'h001, 9'h006};

    repeat (3) @(negedge Clock_100MHz);
    check("reset_pins", {20'd0, LCD_E, LCD_RS, LCD_Data, LCD_RW, Busy}, 32'h001);
    Clear = 1'b0;

    // init sequence timing and content
    n = 0;
    while (LCD_Data !== 8'h38 && n < 100) begin @(negedge Clock_100MHz); n++; end
    check("first_cmd_cycle", n, 20);
    n = 0;
    while (Busy !== 1'b0 && n < 200) begin @(negedge Clock_100MHz); n++; end
    check("init_len", n, 47);
    check("init_count", cap.size(), 4);
    for (int i = 0; i < 4; i++) check("init_byte", cap_at(i), init_exp[i]);

`ifndef LCD_AUTO_REFRESH_EN
    // frame from literal strings; Line_1 changes mid-frame
    l1 = "Status =00000101";
    l2 = "X = 12   Y = 7  ";
    Line_1 = l1; Line_2 = l2;
    cap.delete(); fd_count = 0;
    Refresh = 1'b1; @(negedge Clock_100MHz); Refresh = 1'b0;
    check("busy_rise", Busy, 1);
    n = 0;
    while (Frame_done !== 1'b1 && n < 1000) begin
      @(negedge Clock_100MHz); n++;
      if (cap.size() >= 5) Line_1 = {16{8'h41}};
    end
    check("frame_len", n, 340);
    check("frame_bytes", cap.size(), 34);
    for (int k = 0; k < 34; k++) begin
      if (k == 0)       exp_b = 9'h080;
      else if (k < 17)  exp_b = {1'b1, l1[127 - 8 * (k - 1) -: 8]};
      else if (k == 17) exp_b = 9'h0C0;
      else              exp_b = {1'b1, l2[127 - 8 * (k - 18) -: 8]};
      check("frame_byte", cap_at(k), exp_b);
    end
    check("row1_first", cap_at(1), 9'h153);
    check("row1_last", cap_at(16), 9'h131);
    check("row2_first", cap_at(18), 9'h158);
    @(negedge Clock_100MHz);
    check("idle_after_done", {Busy, Frame_done}, 0);
    check("done_pulses", fd_count, 1);

    // requests during a frame collapse into one more frame
    cap.delete(); fd_count = 0;
    Refresh = 1'b1; @(negedge Clock_100MHz); Refresh = 1'b0;
    repeat (50) @(negedge Clock_100MHz);
    for (int p = 0; p < 3; p++) begin
      Refresh = 1'b1; @(negedge Clock_100MHz); Refresh = 1'b0;
      repeat (20) @(negedge Clock_100MHz);
    end
    n = 0;
    while (Frame_done !== 1'b1 && n < 1000) begin @(negedge Clock_100MHz); n++; end
    check("t4_done1", Frame_done, 1);
    @(negedge Clock_100MHz);
    check("t4_gap_idle", Busy, 0);
    @(negedge Clock_100MHz);
    check("t4_restart", Busy, 1);
    n = 0;
    while (Frame_done !== 1'b1 && n < 1000) begin @(negedge Clock_100MHz); n++; end
    check("t4_done2", Frame_done, 1);
    repeat (400) @(negedge Clock_100MHz);
    check("t4_frames", fd_count, 2);
    check("t4_bytes", cap.size(), 68);
    check("t4_idle", Busy, 0);

    // reset during ROW2 with E high
    cap.delete();
    Refresh = 1'b1; @(negedge Clock_100MHz); Refresh = 1'b0;
    n = 0;
    while (!(cap.size() >= 18 && LCD_E === 1'b1) && n < 1000) begin @(negedge Clock_100MHz); n++; end
    check("t5_row2_e_high", LCD_E, 1);
    Clear = 1'b1; @(negedge Clock_100MHz); Clear = 1'b0;
    check("t5_after_clear", {LCD_E, Busy, LCD_Data}, 10'h100);
    cap.delete();
    n = 0;
    while (LCD_Data !== 8'h38 && n < 100) begin @(negedge Clock_100MHz); n++; end
    check("t5_reinit_wait", n, 20);
    n = 0;
    while (Busy !== 1'b0 && n < 200) begin @(negedge Clock_100MHz); n++; end
    check("t5_init_len", n, 47);
    check("t5_init_count", cap.size(), 4);
    check("t5_init_first", cap_at(0), 9'h038);
`endif

    // randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      Refresh = ($urandom_range(0, 99) < 3);
      if ($urandom_range(0, 19) == 0) Line_1 = {$urandom(), $urandom(), $urandom(), $urandom()};
      if ($urandom_range(0, 19) == 0) Line_2 = {$urandom(), $urandom(), $urandom(), $urandom()};
      Clear = ($urandom_range(0, 1499) == 0);
      @(negedge Clock_100MHz);
    end
    Clear = 1'b0; Refresh = 1'b0;

`ifdef LCD_AUTO_REFRESH_EN
    Clear = 1'b1; @(negedge Clock_100MHz); Clear = 1'b0;
    n = 0;
    while (Busy !== 1'b0 && n < 200) begin @(negedge Clock_100MHz); n++; end
    check("auto_init_len", n, 67);
    fd_count = 0;
    repeat (1250) @(negedge Clock_100MHz);
    check("auto_frames", fd_count, 3);
`endif

    repeat (5) @(negedge Clock_100MHz);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
